shift_queue: RTL and testbench

SHIFT_QUEUE -- requirements
Module: shift_queue

---
 rtl/shift_queue.sv | 127 ++++++++++++
 tb/tb_shift_queue.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_queue.sv
// Shift-register queue: head always at index 0, single or burst append at the tail.
// Latency: accepted pop/append visible on taps/dout/count one cycle after the edge.
// Backpressure: none; rejected appends and empty pops are dropped and flagged on overflow/underflow.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clr               synchronous clear (beats push/pop/burst_load)
//   push, din         append one entry at the tail
//   burst_load,       append BURST entries, burst_din[0] first
//   burst_din
//   pop               drop head, shift remaining entries toward index 0
//   dout, taps        head entry / all storage entries (taps[0] is head)
//   count             valid entries, 0..LEN
//   empty, full       decoded from count
//   overflow,         one-cycle pulses after a dropped append / empty pop
//   underflow
module shift_queue #(
   parameter int WID   = 8,
   parameter int LEN   = 16,
   parameter int BURST = 8,
   localparam int CW   = $clog2(LEN + 1)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr,
   input  logic            push,
   input  logic [WID-1:0]  din,
   input  logic            burst_load,
   input  logic [WID-1:0]  burst_din [BURST],
   input  logic            pop,
   output logic [WID-1:0]  dout,
   output logic [WID-1:0]  taps [LEN],
   output logic [CW-1:0]   count,
   output logic            empty,
   output logic            full,
   output logic            overflow,
   output logic            underflow
);

   logic [WID-1:0] ent     [LEN];
   logic [WID-1:0] ent_nxt [LEN];
   logic [CW-1:0]  cnt_nxt;
   logic           ovf_nxt;
   logic           unf_nxt;
   int             tail;

   // Pop is resolved first; the append then targets the post-pop tail, so a
   // push+pop on a full queue still fits.
   always_comb begin
      ent_nxt = ent;
      cnt_nxt = count;
      ovf_nxt = 1'b0;
      unf_nxt = 1'b0;
      tail    = 0;

      if (pop) begin
         if (count != '0) begin
            for (int i = 0; i < LEN - 1; i++) begin
               ent_nxt[i] = ent[i + 1];
            end
            ent_nxt[LEN-1] = '0;
            cnt_nxt        = count - CW'(1);
         end else begin
            unf_nxt = 1'b1;
         end
      end

      tail = int'(cnt_nxt);

      if (burst_load) begin
         // A push alongside a burst always loses, even if the burst is rejected.
         if (push) begin
            ovf_nxt = 1'b1;
         end
         if (LEN - tail >= BURST) begin
            for (int i = 0; i < LEN; i++) begin
               if (i >= tail && i < tail + BURST) begin
                  ent_nxt[i] = burst_din[i - tail];
               end
            end
            cnt_nxt = cnt_nxt + CW'(BURST);
         end else begin
            ovf_nxt = 1'b1;
         end
      end else if (push) begin
         if (tail < LEN) begin
            for (int i = 0; i < LEN; i++) begin
               if (i == tail) begin
                  ent_nxt[i] = din;
               end
            end
            cnt_nxt = cnt_nxt + CW'(1);
         end else begin
            ovf_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LEN; i++) begin
            ent[i] <= '0;
         end
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < LEN; i++) begin
            ent[i] <= '0;
         end
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         ent       <= ent_nxt;
         count     <= cnt_nxt;
         overflow  <= ovf_nxt;
         underflow <= unf_nxt;
      end
   end

   assign taps  = ent;
   assign dout  = ent[0];
   assign empty = (count == '0);
   assign full  = (count == CW'(LEN));

endmodule

// File: tb/tb_shift_queue.sv
module tb_shift_queue;

   localparam int WID   = 8;
   localparam int LEN   = 16;
   localparam int BURST = 8;
   localparam int CW    = $clog2(LEN + 1);

   typedef logic [WID-1:0] bvec_t [BURST];

   logic            clk;
   logic            reset_n;
   logic            clr;
   logic            push;
   logic [WID-1:0]  din;
   logic            burst_load;
   logic [WID-1:0]  burst_din [BURST];
   logic            pop;
   logic [WID-1:0]  dout;
   logic [WID-1:0]  taps [LEN];
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;
   logic            overflow;
   logic            underflow;

   shift_queue #(.WID(WID), .LEN(LEN), .BURST(BURST)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (clr),
      .push       (push),
      .din        (din),
      .burst_load (burst_load),
      .burst_din  (burst_din),
      .pop        (pop),
      .dout       (dout),
      .taps       (taps),
      .count      (count),
      .empty      (empty),
      .full       (full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: a plain queue of values plus the two flag bits.
   int q[$];
   bit m_ovf;
   bit m_unf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input bit c, input bit ps, input bit pp, input bit bl,
                             input logic [WID-1:0] d, input bvec_t bd);
      if (c) begin
         model_reset();
         return;
      end
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (pp) begin
         if (q.size() > 0) void'(q.pop_front());
         else m_unf = 1'b1;
      end
      if (bl) begin
         if (ps) m_ovf = 1'b1;
         if (LEN - q.size() >= BURST) begin
            for (int k = 0; k < BURST; k++) q.push_back(int'(bd[k]));
         end else begin
            m_ovf = 1'b1;
         end
      end else if (ps) begin
         if (q.size() < LEN) q.push_back(int'(d));
         else m_ovf = 1'b1;
      end
   endtask

   task automatic check_model(input string nm);
      int bad;
      int expv;
      bad = -1;
      for (int i = 0; i < LEN; i++) begin
         expv = (i < q.size()) ? q[i] : 0;
         if (taps[i] !== WID'(expv) && bad < 0) bad = i;
      end
      n_chk++;
      if (bad < 0) n_pass++;
      else $display("FAIL %s taps[%0d]: got %0h expected %0h", nm, bad, taps[bad],
                    (bad < q.size()) ? q[bad] : 0);
      chk({nm, " count"}, 32'(count), 32'(q.size()));
      chk({nm, " dout"}, 32'(dout), (q.size() > 0) ? 32'(q[0]) : 32'd0);
      chk({nm, " empty"}, 32'(empty), 32'(q.size() == 0));
      chk({nm, " full"}, 32'(full), 32'(q.size() == LEN));
      chk({nm, " ovf"}, 32'(overflow), 32'(m_ovf));
      chk({nm, " unf"}, 32'(underflow), 32'(m_unf));
   endtask

   // Drive one cycle's inputs (called just after a negedge), clock them in,
   // update the model and sample at the following negedge.
   task automatic step(input bit c, input bit ps, input bit pp, input bit bl,
                       input logic [WID-1:0] d, input bvec_t bd);
      clr        = c;
      push       = ps;
      pop        = pp;
      burst_load = bl;
      din        = d;
      burst_din  = bd;
      @(posedge clk);
      model_step(c, ps, pp, bl, d, bd);
      @(negedge clk);
      clr = 1'b0; push = 1'b0; pop = 1'b0; burst_load = 1'b0;
   endtask

   function automatic bvec_t mkburst(input logic [WID-1:0] base);
      bvec_t b;
      for (int k = 0; k < BURST; k++) b[k] = base + WID'(k);
      return b;
   endfunction

   typedef struct {
      bit             c, ps, pp, bl;
      logic [WID-1:0] d;
      logic [WID-1:0] bbase;
      int             cnt;
      logic [WID-1:0] dout;
      bit             ovf, unf;
      string          nm;
   } vec_t;

   vec_t vt[$];

   initial begin
      bvec_t bz;
      bz = mkburst(8'h00);
      reset_n = 1'b0;
      clr = 1'b0; push = 1'b0; pop = 1'b0; burst_load = 1'b0; din = '0;
      burst_din = bz;
      model_reset();

      // Reset state, before any clock edge.
      #1;
      check_model("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Directed vectors: {clr,push,pop,burst,din,burst base} -> {count,dout,ovf,unf}
      vt.push_back('{0,0,0,1, 8'h00, 8'h10,  8, 8'h10, 0, 0, "burst1"});
      vt.push_back('{0,0,0,1, 8'h00, 8'h18, 16, 8'h10, 0, 0, "burst2"});
      vt.push_back('{0,0,0,1, 8'h00, 8'h20, 16, 8'h10, 1, 0, "burst3_drop"});
      vt.push_back('{0,0,0,0, 8'h00, 8'h00, 16, 8'h10, 0, 0, "ovf_clears"});
      vt.push_back('{0,0,1,1, 8'h00, 8'h30, 15, 8'h11, 1, 0, "pop_burst_full"});
      vt.push_back('{0,1,1,0, 8'hAA, 8'h00, 15, 8'h12, 0, 0, "pop_push_15"});
      vt.push_back('{1,0,0,0, 8'h00, 8'h00,  0, 8'h00, 0, 0, "clr"});
      vt.push_back('{0,1,1,0, 8'h5C, 8'h00,  1, 8'h5C, 0, 1, "pop_push_empty"});
      vt.push_back('{0,0,1,0, 8'h00, 8'h00,  0, 8'h00, 0, 0, "pop_last"});
      vt.push_back('{0,0,1,0, 8'h00, 8'h00,  0, 8'h00, 0, 1, "pop_empty"});
      vt.push_back('{0,0,0,1, 8'h00, 8'h40,  8, 8'h40, 0, 0, "burst_to_8"});
      vt.push_back('{0,1,0,0, 8'h99, 8'h00,  9, 8'h40, 0, 0, "push_to_9"});
      vt.push_back('{0,1,0,1, 8'h77, 8'h50,  9, 8'h40, 1, 0, "burst_push_9"});
      vt.push_back('{0,0,0,0, 8'h00, 8'h00,  9, 8'h40, 0, 0, "idle_9"});
      vt.push_back('{1,1,1,0, 8'h33, 8'h00,  0, 8'h00, 0, 0, "clr_pop_push"});

      foreach (vt[i]) begin
         step(vt[i].c, vt[i].ps, vt[i].pp, vt[i].bl, vt[i].d, mkburst(vt[i].bbase));
         chk({vt[i].nm, " tbl_count"}, 32'(count), 32'(vt[i].cnt));
         chk({vt[i].nm, " tbl_dout"}, 32'(dout), 32'(vt[i].dout));
         chk({vt[i].nm, " tbl_ovf"}, 32'(overflow), 32'(vt[i].ovf));
         chk({vt[i].nm, " tbl_unf"}, 32'(underflow), 32'(vt[i].unf));
         check_model(vt[i].nm);
      end
      // After pop_push_15 the new entry sits at index 14 (checked by name here too).

      // Asynchronous reset mid-operation, with an overflow pulse live.
      step(0, 0, 0, 1, 8'h00, mkburst(8'h60));
      step(0, 1, 0, 0, 8'h68, bz);
      step(0, 1, 0, 0, 8'h69, bz);
      step(0, 1, 0, 0, 8'h6A, bz);
      step(0, 1, 0, 0, 8'h6B, bz);
      step(0, 0, 0, 1, 8'h00, mkburst(8'h70));
      chk("pre_reset count", 32'(count), 32'd12);
      chk("pre_reset ovf", 32'(overflow), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_model("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      step(0, 1, 0, 0, 8'h01, bz);
      chk("post_reset count", 32'(count), 32'd1);
      chk("post_reset dout", 32'(dout), 32'h01);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, WID'(i + 2), bz);
      chk("count5", 32'(count), 32'd5);
      step(1, 0, 1, 0, 8'h00, bz);
      chk("clr5 count", 32'(count), 32'd0);
      chk("clr5 unf", 32'(underflow), 32'd0);
      check_model("clr5");

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         bvec_t rb;
         bit c, ps, pp, bl;
         for (int k = 0; k < BURST; k++) rb[k] = WID'($urandom);
         c  = ($urandom_range(0, 63) == 0);
         ps = ($urandom_range(0, 1) == 1);
         pp = ($urandom_range(0, 9) < 4);
         bl = ($urandom_range(0, 9) < 2);
         step(c, ps, pp, bl, WID'($urandom), rb);
         check_model("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
